count_hex_display: RTL and testbench

- Downstream consumer of the 8-bit up/down counter's `count` bus.
- Snapshots the count once per display frame and time-multiplexes it onto a 2-digit hex seven-segment display: digit 0 is the low nibble, digit 1 is the high nibble.
- Provides a scan prescaler, a hold/freeze control, optional leading-zero blanking and a frame-complete strobe for the bench and for later logging logic.

---
 rtl/count_hex_display.sv | 95 +++++++++
 tb/tb_count_hex_display.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/count_hex_display.sv
// rtl/count_hex_display.sv - snapshot an 8-bit count once per frame and scan it onto a 2-digit hex display
module count_hex_display #(
   parameter int unsigned SCAN_DIV = 4,
   parameter bit          BLANK_LZ = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] count,
   input  logic       hold,
   output logic [6:0] seg,
   output logic [1:0] an,
   output logic       frame
);

   localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

   logic [15:0] div_cnt;
   logic        digit_sel;
   logic [7:0]  snap;
   logic        tick;
   logic        frame_end;
   logic [3:0]  nib;
   logic [6:0]  seg_dec;
   logic        blank;

   assign tick      = (div_cnt == DIV_LAST);
   assign frame_end = tick && digit_sel;
   assign nib       = digit_sel ? snap[7:4] : snap[3:0];
   assign blank     = BLANK_LZ && digit_sel && (snap[7:4] == 4'h0);

   always_comb begin
      seg_dec = 7'h00;
      case (nib)
         4'h0: seg_dec = 7'h3F;
         4'h1: seg_dec = 7'h06;
         4'h2: seg_dec = 7'h5B;
         4'h3: seg_dec = 7'h4F;
         4'h4: seg_dec = 7'h66;
         4'h5: seg_dec = 7'h6D;
         4'h6: seg_dec = 7'h7D;
         4'h7: seg_dec = 7'h07;
         4'h8: seg_dec = 7'h7F;
         4'h9: seg_dec = 7'h6F;
         4'hA: seg_dec = 7'h77;
         4'hB: seg_dec = 7'h7C;
         4'hC: seg_dec = 7'h39;
         4'hD: seg_dec = 7'h5E;
         4'hE: seg_dec = 7'h79;
         4'hF: seg_dec = 7'h71;
         default: seg_dec = 7'h00;
      endcase
   end

   // Scan timing: prescaler wraps every SCAN_DIV cycles, each wrap flips the digit slot.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt   <= 16'h0000;
         digit_sel <= 1'b0;
      end else begin
         if (tick) begin
            div_cnt   <= 16'h0000;
            digit_sel <= ~digit_sel;
         end else begin
            div_cnt <= div_cnt + 16'h0001;
         end
      end
   end

   // The count is only ever sampled at frame end, so a frame always shows one coherent value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         snap  <= 8'h00;
         frame <= 1'b0;
      end else begin
         frame <= frame_end;
         if (frame_end && !hold) begin
            snap <= count;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an  <= 2'b00;
         seg <= 7'h00;
      end else if (blank) begin
         an  <= 2'b00;
         seg <= 7'h00;
      end else begin
         an  <= digit_sel ? 2'b10 : 2'b01;
         seg <= seg_dec;
      end
   end

endmodule

// File: tb/tb_count_hex_display.sv
// tb/tb_count_hex_display.sv - directed bench with a cycle-count display model for count_hex_display
module tb_count_hex_display;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] count = 8'hA5;
   logic       hold = 1'b0;
   logic [6:0] seg_d [3];
   logic [1:0] an_d [3];
   logic       frame_d [3];

   int checks = 0;
   int failures = 0;
   bit started = 1'b0;

   logic [6:0] hex7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   count_hex_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_a (
      .clk(clk), .reset(reset), .count(count), .hold(hold),
      .seg(seg_d[0]), .an(an_d[0]), .frame(frame_d[0]));
   count_hex_display #(.SCAN_DIV(1), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .reset(reset), .count(count), .hold(hold),
      .seg(seg_d[1]), .an(an_d[1]), .frame(frame_d[1]));
   count_hex_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut_c (
      .clk(clk), .reset(reset), .count(count), .hold(hold),
      .seg(seg_d[2]), .an(an_d[2]), .frame(frame_d[2]));

   initial forever #5 clk = ~clk;

   function automatic int div_of(input int i);
      return (i == 1) ? 1 : 4;
   endfunction

   function automatic bit blank_of(input int i);
      return (i == 2);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: edge n after reset release shows slot floor((n-1)/D) mod 2; frame ends at edges n = k*2D.
   int         n_m [3] = '{0, 0, 0};
   logic [7:0] snap_m [3] = '{8'h00, 8'h00, 8'h00};
   logic [6:0] seg_m [3] = '{7'h00, 7'h00, 7'h00};
   logic [1:0] an_m [3] = '{2'b00, 2'b00, 2'b00};
   logic       frame_m [3] = '{1'b0, 1'b0, 1'b0};

   always @(posedge clk or negedge reset) begin
      int d;
      int sel;
      if (!reset) begin
         for (int i = 0; i < 3; i++) begin
            n_m[i] = 0; snap_m[i] = 8'h00; seg_m[i] = 7'h00; an_m[i] = 2'b00; frame_m[i] = 1'b0;
         end
      end else begin
         for (int i = 0; i < 3; i++) begin
            d = div_of(i);
            n_m[i] = n_m[i] + 1;
            sel = ((n_m[i] - 1) / d) % 2;
            if (sel == 1 && blank_of(i) && snap_m[i][7:4] == 4'h0) begin
               an_m[i] = 2'b00; seg_m[i] = 7'h00;
            end else begin
               an_m[i]  = (sel == 1) ? 2'b10 : 2'b01;
               seg_m[i] = hex7[(sel == 1) ? snap_m[i][7:4] : snap_m[i][3:0]];
            end
            frame_m[i] = ((n_m[i] % (2 * d)) == 0);
            if (frame_m[i] && !hold) snap_m[i] = count;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_seg%0d", i), 16'(seg_d[i]), 16'(seg_m[i]));
            chk($sformatf("model_an%0d", i), 16'(an_d[i]), 16'(an_m[i]));
            chk($sformatf("model_frame%0d", i), 16'(frame_d[i]), 16'(frame_m[i]));
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_frame_a();
      int k;
      for (k = 0; k < 20; k++) begin
         step();
         if (frame_d[0]) break;
      end
      chk("wait_frame_a", 16'(frame_d[0]), 16'h1);
   endtask

   // Releases reset (count=A5) and pins the model with hand-computed values for each edge.
   task automatic scenario1();
      count = 8'hA5;
      hold  = 1'b0;
      step();
      reset = 1'b1;
      for (int e = 1; e <= 16; e++) begin
         step();
         case (e)
            1: begin
               chk("s1_a_an_e1", 16'(an_d[0]), 16'h1);   chk("s1_a_seg_e1", 16'(seg_d[0]), 16'h3F);
               chk("s1_b_an_e1", 16'(an_d[1]), 16'h1);   chk("s1_c_seg_e1", 16'(seg_d[2]), 16'h3F);
            end
            2: begin
               chk("s1_b_an_e2", 16'(an_d[1]), 16'h2);   chk("s1_b_frame_e2", 16'(frame_d[1]), 16'h1);
            end
            3: begin
               chk("s1_b_an_e3", 16'(an_d[1]), 16'h1);   chk("s1_b_seg_e3", 16'(seg_d[1]), 16'h6D);
               chk("s1_b_frame_e3", 16'(frame_d[1]), 16'h0);
            end
            4: chk("s1_b_seg_e4", 16'(seg_d[1]), 16'h77);
            5: begin
               chk("s1_a_an_e5", 16'(an_d[0]), 16'h2);   chk("s1_a_seg_e5", 16'(seg_d[0]), 16'h3F);
               chk("s1_c_an_e5", 16'(an_d[2]), 16'h0);   chk("s1_c_seg_e5", 16'(seg_d[2]), 16'h00);
            end
            7: chk("s1_a_frame_e7", 16'(frame_d[0]), 16'h0);
            8: chk("s1_a_frame_e8", 16'(frame_d[0]), 16'h1);
            9: chk("s1_a_frame_e9", 16'(frame_d[0]), 16'h0);
            10: begin
               chk("s1_a_an_e10", 16'(an_d[0]), 16'h1);  chk("s1_a_seg_e10", 16'(seg_d[0]), 16'h6D);
            end
            14: begin
               chk("s1_a_an_e14", 16'(an_d[0]), 16'h2);  chk("s1_a_seg_e14", 16'(seg_d[0]), 16'h77);
               chk("s1_c_an_e14", 16'(an_d[2]), 16'h2);  chk("s1_c_seg_e14", 16'(seg_d[2]), 16'h77);
            end
            default: ;
         endcase
      end
   endtask

   initial begin
      int fa, fb, blanks;
      logic [7:0] prev, latched;
      bit pending;
      #1 reset = 1'b0;
      #1 started = 1'b1;
      chk("reset_an", 16'(an_d[0]), 16'h0);
      chk("reset_seg", 16'(seg_d[0]), 16'h0);
      chk("reset_frame", 16'(frame_d[0]), 16'h0);
      step();
      scenario1();

      // Hold: display stays on A5 for three frames while count moves to 3C.
      hold = 1'b1;
      count = 8'h3C;
      fa = 0; fb = 0;
      for (int k = 0; k < 24; k++) begin
         step();
         if (frame_d[0]) fa++;
         if (frame_d[1]) fb++;
      end
      chk("hold_frames_a", 16'(fa), 16'd3);
      chk("hold_frames_b", 16'(fb), 16'd12);
      for (int k = 0; k < 8; k++) begin
         step();
         chk("hold_seg_a", 16'(seg_d[0]), (an_d[0] == 2'b01) ? 16'h6D : 16'h77);
      end
      hold = 1'b0;
      wait_frame_a();
      for (int k = 0; k < 8; k++) begin
         step();
         chk("unhold_seg_a", 16'(seg_d[0]), (an_d[0] == 2'b01) ? 16'h39 : 16'h4F);
      end

      // Leading-zero blanking on dut_c.
      count = 8'h07;
      wait_frame_a();
      blanks = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (an_d[2] == 2'b00) begin
            blanks++;
            chk("blank07_seg", 16'(seg_d[2]), 16'h00);
         end else begin
            chk("blank07_an0", 16'(an_d[2]), 16'h1);
            chk("blank07_seg0", 16'(seg_d[2]), 16'h07);
         end
      end
      chk("blank07_slots", 16'(blanks), 16'd4);
      count = 8'h00;
      wait_frame_a();
      blanks = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("zero_seg_a", 16'(seg_d[0]), 16'h3F);
         if (an_d[2] == 2'b00) blanks++;
         else chk("zero_seg_c", 16'(seg_d[2]), 16'h3F);
      end
      chk("zero_blank_slots", 16'(blanks), 16'd4);

      // Reset asserted mid digit-1 slot clears outputs without a clock edge.
      count = 8'hA5;
      wait_frame_a();
      for (int k = 0; k < 5; k++) step();
      chk("mid_an_before", 16'(an_d[0]), 16'h2);
      #2 reset = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("mid_rst_an%0d", i), 16'(an_d[i]), 16'h0);
         chk($sformatf("mid_rst_seg%0d", i), 16'(seg_d[i]), 16'h0);
         chk($sformatf("mid_rst_frame%0d", i), 16'(frame_d[i]), 16'h0);
      end
      scenario1();

      // Live up then down counter; each frame loads the count present at that edge.
      pending = 1'b0;
      latched = 8'h00;
      for (int k = 0; k < 240; k++) begin
         prev = count;
         step();
         if (pending) begin
            chk("live_seg0", 16'(seg_d[0]), 16'(hex7[latched[3:0]]));
            pending = 1'b0;
         end
         if (frame_d[0]) begin
            latched = prev;
            pending = 1'b1;
         end
         count = (k < 120) ? count + 8'h01 : count - 8'h01;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
